// File: rtl/wide_adder_seq_pkg.sv
// wide_adder_seq_pkg: word width and FSM state encoding shared by the wide adder slice
package wide_adder_seq_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADD = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/wide_adder_seq_if.sv
// wide_adder_seq_if: operand (in_valid/in_ready/a/b/cin) and result (out_valid/out_ready/s/cout[/ovf with WIDE_ADD_OVF_EN]) bundle; slave=adder, master=source+consumer
interface wide_adder_seq_if #(parameter int NWORDS = 4);
  localparam int W = wide_adder_seq_pkg::WORD_W * NWORDS;
  logic in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [W-1:0] a, b, s;
`ifdef WIDE_ADD_OVF_EN
  logic ovf;
  modport slave(input in_valid, a, b, cin, out_ready, output in_ready, out_valid, s, cout, ovf);
  modport master(output in_valid, a, b, cin, out_ready, input in_ready, out_valid, s, cout, ovf);
`else
  modport slave(input in_valid, a, b, cin, out_ready, output in_ready, out_valid, s, cout);
  modport master(output in_valid, a, b, cin, out_ready, input in_ready, out_valid, s, cout);
`endif
endinterface

// File: rtl/wide_adder_seq_cska.sv
// wide_adder_seq_cska: 32-bit carry-skip adder (a, b, cin -> s, cout), 4-bit blocks whose carry bypasses the block when every bit propagates
module wide_adder_seq_cska (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  logic [8:0] c;
  assign c[0] = cin;
  for (genvar g = 0; g < 8; g++) begin : g_blk
    logic [3:0] p;
    logic [4:0] r;
    assign p = a[4*g +: 4] ^ b[4*g +: 4];
    assign r = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]} + {4'b0, c[g]};
    assign s[4*g +: 4] = r[3:0];
    assign c[g+1] = &p ? c[g] : r[4];
  end
  assign cout = c[8];
endmodule

// File: rtl/wide_adder_seq.sv
// wide_adder_seq: multi-cycle 32*NWORDS-bit adder, one carry-skip word per clock LSW first; ports clk, rst_n (async low), bus (wide_adder_seq_if.slave); WIDE_ADD_OVF_EN adds signed overflow ovf
module wide_adder_seq
  import wide_adder_seq_pkg::*;
#(parameter int NWORDS = 4) (
  input logic clk,
  input logic rst_n,
  wide_adder_seq_if.slave bus
);
  localparam int W = WORD_W * NWORDS;
  localparam int IW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  state_t state, state_nx;
  logic live, carry, cout_r, co, last;
  logic [IW-1:0] idx;
  logic [W-1:0] a_r, b_r, s_r;
  logic [WORD_W-1:0] aw, bw, sw;
  assign aw = a_r[{idx, 5'd0} +: WORD_W];
  assign bw = b_r[{idx, 5'd0} +: WORD_W];
  wide_adder_seq_cska u_slice (.a(aw), .b(bw), .cin(carry), .s(sw), .cout(co));
  assign last = idx == IW'(NWORDS - 1);
  assign bus.in_ready = live && state == ST_IDLE;
  assign bus.out_valid = state == ST_DONE;
  assign bus.s = s_r;
  assign bus.cout = cout_r;
`ifdef WIDE_ADD_OVF_EN
  logic ovf_r;
  assign bus.ovf = ovf_r;
`endif
  always_comb begin
    state_nx = state == ST_IDLE ? (bus.in_valid && live ? ST_ADD : ST_IDLE) :
               state == ST_ADD  ? (last ? ST_DONE : ST_ADD) :
               state == ST_DONE ? (bus.out_ready ? ST_IDLE : ST_DONE) : ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= 1'b0;
      carry <= 1'b0;
      cout_r <= 1'b0;
      idx <= '0;
      a_r <= '0;
      b_r <= '0;
      s_r <= '0;
`ifdef WIDE_ADD_OVF_EN
      ovf_r <= 1'b0;
`endif
    end else begin
      live <= 1'b1;
      if (bus.in_ready && bus.in_valid) begin
        a_r <= bus.a;
        b_r <= bus.b;
        carry <= bus.cin;
        idx <= '0;
      end
      if (state == ST_ADD) begin
        s_r[{idx, 5'd0} +: WORD_W] <= sw;
        carry <= co;
        idx <= idx + IW'(1);
        if (last) begin
          cout_r <= co;
`ifdef WIDE_ADD_OVF_EN
          ovf_r <= sw[WORD_W-1] ^ aw[WORD_W-1] ^ bw[WORD_W-1] ^ co;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_wide_adder_seq.sv
// tb_wide_adder_seq: random and directed stimulus for wide_adder_seq checked against an integer-sum reference model
module tb_wide_adder_seq;
  localparam int NW = 4;
  localparam int W = 32 * NW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  wide_adder_seq_if #(.NWORDS(NW)) bus();
  wide_adder_seq #(.NWORDS(NW)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [W:0] sum; logic ovf; int t;} exp_t;
  exp_t q[$];
  bit seen = 0;
  task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask
  task automatic chk1(input string nm, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, req);
    end
  endtask
  task automatic chki(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int t);
    exp_t e;
    e.sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.ovf = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    e.t = t;
    return e;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      seen = 0;
      chk1("rst_out_valid", bus.out_valid, 1'b0);
      chk1("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_sum", {bus.cout, bus.s}, '0);
`ifdef WIDE_ADD_OVF_EN
      chk1("rst_ovf", bus.ovf, 1'b0);
`endif
    end else begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out_valid: got 1 want 0");
        end else begin
          if (!seen) begin
            chki("latency", cyc - q[0].t, NW + 1);
            seen = 1;
          end
          chk("model_sum", {bus.cout, bus.s}, q[0].sum);
`ifdef WIDE_ADD_OVF_EN
          chk1("model_ovf", bus.ovf, q[0].ovf);
`endif
          if (bus.out_ready) begin
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b, bus.cin, cyc));
    end
  end
  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    for (int i = 0; i < NW; i++) begin
      int k;
      k = $urandom_range(0, 3);
      v[32*i +: 32] = k == 0 ? 32'h0 : k == 1 ? 32'hFFFF_FFFF : $urandom;
    end
    return v;
  endfunction
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input int hold,
                        output logic [W:0] res, output logic ovf, output int lat);
    bit ok;
    int t0;
    @(posedge clk); #1;
    bus.a = a; bus.b = b; bus.cin = cin; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = bus.in_ready; end
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL accept_timeout: got in_ready 0 want 1"); end
    t0 = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = rnd_op(); bus.b = rnd_op(); bus.cin = ~cin;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = bus.out_valid; end
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL result_timeout: got out_valid 0 want 1"); end
    lat = cyc - t0;
    res = {bus.cout, bus.s};
`ifdef WIDE_ADD_OVF_EN
    ovf = bus.ovf;
`else
    ovf = 1'b0;
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.a = rnd_op(); bus.b = rnd_op();
      @(negedge clk);
      chk("bp_held_sum", {bus.cout, bus.s}, res);
      chk1("bp_in_ready", bus.in_ready, 1'b0);
      chk1("bp_out_valid", bus.out_valid, 1'b1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk1("after_xfer_out_valid", bus.out_valid, 1'b0);
    chk1("after_xfer_in_ready", bus.in_ready, 1'b1);
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [W:0] res;
    logic ovf;
    int lat, ops, guard;
    bit took;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk1("in_ready_before_first_clk", bus.in_ready, 1'b0);
    @(negedge clk);
    chk1("in_ready_after_release", bus.in_ready, 1'b1);
    run_op('0, '0, 1'b0, 0, res, ovf, lat);
    chk("t1_zero", res, '0);
    chki("t1_latency", lat, 5);
    run_op({W{1'b1}}, '0, 1'b1, 0, res, ovf, lat);
    chk("t2_ripple", res, {1'b1, {W{1'b0}}});
`ifdef WIDE_ADD_OVF_EN
    chk1("t2_ovf", ovf, 1'b0);
`endif
    run_op(W'(32'hFFFF_0000), W'(32'h0000_FFFF), 1'b1, 0, res, ovf, lat);
    chk("t3_word_boundary", res, (W+1)'(64'h1_0000_0000));
    run_op({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 0, res, ovf, lat);
    chk("t4_pos_ovf", res, {2'b01, {(W-1){1'b0}}});
`ifdef WIDE_ADD_OVF_EN
    chk1("t4_pos_ovf_flag", ovf, 1'b1);
`endif
    run_op({1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, 1'b0, 0, res, ovf, lat);
    chk("t4_neg_ovf", res, {1'b1, {W{1'b0}}});
`ifdef WIDE_ADD_OVF_EN
    chk1("t4_neg_ovf_flag", ovf, 1'b1);
`endif
    run_op(W'(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321), W'(128'h1111_1111_1111_1111_1111_1111_1111_1111), 1'b0, 6, res, ovf, lat);
    chk("t5_backpressure", res, (W+1)'(128'h2345_6789_ABCD_F001_20FE_DCBA_9876_5432));
    @(posedge clk); #1;
    bus.a = rnd_op(); bus.b = rnd_op(); bus.cin = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    chk1("t6_accept_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk1("t6_abort_out_valid", bus.out_valid, 1'b0);
    chk("t6_abort_sum", {bus.cout, bus.s}, '0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(W'(32'd2017701177), W'(32'd1701853), 1'b0, 0, res, ovf, lat);
    chk("t6_after_reset", res, (W+1)'(32'h785D_A516));
    ops = 0;
    guard = 0;
    while (ops < 1000 && guard < 40000) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      guard++;
      bus.out_ready = 1'($urandom_range(0, 1));
      if (took) begin bus.in_valid = 1'b0; ops++; end
      if (!bus.in_valid && ops < 1000 && $urandom_range(0, 3) != 0) begin
        bus.a = rnd_op(); bus.b = rnd_op(); bus.cin = 1'($urandom_range(0, 1)); bus.in_valid = 1'b1;
      end else if (!bus.in_valid) begin
        bus.a = rnd_op(); bus.b = rnd_op(); bus.cin = 1'($urandom_range(0, 1));
      end
    end
    chki("random_ops_done", ops, 1000);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 50) begin @(negedge clk); guard++; end
    chki("drain_queue", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
